// File: rtl/mux4_scan_pkg.sv
// Shared definitions for the mux4 scan sequencer: the state encoding and the
// channel/select geometry of the downstream 4:1 mux.
package mux4_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;

endpackage

// File: rtl/rr_next4.sv
// Round-robin pick over a 4-bit mask: the next set bit strictly above cur,
// wrapping modulo 4. With cur = 3 this yields the lowest set bit.
module rr_next4
    import mux4_scan_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic             wrap,
    output logic             none
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        cand  = '0;
        // Candidates cur+1 .. cur+4; the last one is cur itself, covering a lone channel
        for (int k = 1; k <= NCH; k++) begin
            cand = cur + SEL_W'(k);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    assign none = ~|mask;
    assign wrap = (nxt <= cur);

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for mux4: steps sel round-robin over enabled channels, holds
// each for dwell+1 cycles, and publishes a per-sweep snapshot with a valid pulse.
module mux4_scan_ctrl
    import mux4_scan_pkg::*;
#(
    parameter int DWELL_W = 4
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NCH-1:0]     chan_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic [SEL_W-1:0]   sel,
    output logic [NCH-1:0]     sample,
    output logic               sample_valid,
    output logic               busy
);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [DWELL_W-1:0] counter, counter_nxt;
    logic [NCH-1:0]     shadow, shadow_nxt;
    logic [NCH-1:0]     sample_nxt;
    logic               valid_nxt;
    logic [NCH-1:0]     captured;

    logic [SEL_W-1:0]   rr_cur;
    logic [SEL_W-1:0]   rr_nxt;
    logic               rr_wrap;
    logic               rr_none;

    // From IDLE, searching above the top channel returns the lowest enabled one
    assign rr_cur = (state == S_IDLE) ? SEL_W'(NCH - 1) : sel;

    rr_next4 u_rr (
        .mask (chan_en),
        .cur  (rr_cur),
        .nxt  (rr_nxt),
        .wrap (rr_wrap),
        .none (rr_none)
    );

    always_comb begin
        captured      = shadow;
        captured[sel] = mux_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            sel          <= '0;
            counter      <= '0;
            shadow       <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            counter      <= counter_nxt;
            shadow       <= shadow_nxt;
            sample       <= sample_nxt;
            sample_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        counter_nxt = counter;
        shadow_nxt  = shadow;
        sample_nxt  = sample;
        valid_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && !rr_none) begin
                    sel_nxt     = rr_nxt;
                    counter_nxt = dwell;
                    shadow_nxt  = '0;
                    state_nxt   = S_DWELL;
                end
            end
            S_DWELL: begin
                if (counter != '0) begin
                    counter_nxt = counter - DWELL_W'(1);
                end else if (rr_none) begin
                    // Mask emptied: abandon the sweep without publishing
                    shadow_nxt = captured;
                    state_nxt  = S_IDLE;
                end else begin
                    sel_nxt     = rr_nxt;
                    counter_nxt = dwell;
                    if (rr_wrap) begin
                        sample_nxt = captured;
                        valid_nxt  = 1'b1;
                        shadow_nxt = '0;
                        if (!en) state_nxt = S_IDLE;
                    end else begin
                        shadow_nxt = captured;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_DWELL);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: directed scenarios followed by random traffic,
// compared each cycle against a channel/sweep-level reference model.
module tb_mux4_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] chan_en;
    logic [3:0] dwell;
    logic [3:0] data;
    logic       mux_out;
    logic [1:0] sel;
    logic [3:0] sample;
    logic       sample_valid;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Downstream mux4 in the loop: purely combinational
    assign mux_out = data[sel];

    mux4_scan_ctrl #(.DWELL_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .chan_en      (chan_en),
        .dwell        (dwell),
        .mux_out      (mux_out),
        .sel          (sel),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    // Reference model: which channel is being watched, how many hold cycles
    // remain, the values gathered so far this sweep, and the published snapshot.
    bit       m_active = 1'b0;
    int       m_ch     = 0;
    int       m_left   = 0;
    bit [3:0] m_snap   = '0;
    bit [3:0] m_sample = '0;
    bit       m_valid  = 1'b0;

    function automatic int next_enabled(bit [3:0] m, int c);
        for (int k = 1; k <= 4; k++)
            if (m[(c + k) % 4]) return (c + k) % 4;
        return c;
    endfunction

    task automatic model_step();
        int nx;
        m_valid = 1'b0;
        if (reset) begin
            m_active = 1'b0; m_ch = 0; m_left = 0; m_snap = '0; m_sample = '0;
        end else if (!m_active) begin
            if (en && chan_en != 0) begin
                m_ch = next_enabled(chan_en, 3);
                m_left = int'(dwell); m_snap = '0; m_active = 1'b1;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            m_snap[m_ch] = data[m_ch];
            if (chan_en == 0) begin
                m_active = 1'b0;
            end else begin
                nx = next_enabled(chan_en, m_ch);
                m_left = int'(dwell);
                if (nx <= m_ch) begin
                    m_sample = m_snap; m_valid = 1'b1; m_snap = '0;
                    if (!en) m_active = 1'b0;
                end
                m_ch = nx;
            end
        end
    endtask

    task automatic cmp(string tag, int got, int exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cmp("sel", int'(sel), m_ch);
        cmp("sample", int'(sample), int'(m_sample));
        cmp("sample_valid", int'(sample_valid), int'(m_valid));
        cmp("busy", int'(busy), int'(m_active));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int pulses;

    initial begin
        reset = 1'b1; en = 1'b0; chan_en = 4'h0; dwell = 4'd0; data = 4'h0;
        run(2);
        reset = 1'b0;
        run(2);

        // Reset in the middle of a sweep
        en = 1'b1; chan_en = 4'b1111; dwell = 4'd2;
        run(4);
        reset = 1'b1;
        tick();
        cmp("rst_sel", int'(sel), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_sample", int'(sample), 0);
        cmp("rst_valid", int'(sample_valid), 0);
        reset = 1'b0; en = 1'b0;
        run(2);

        // Full sweep, a=1 b=0 c=1 d=1, one cycle per channel
        data = 4'b1101; chan_en = 4'b1111; dwell = 4'd0; en = 1'b1;
        tick();
        cmp("full_busy", int'(busy), 1);
        run(4);
        cmp("full_valid", int'(sample_valid), 1);
        cmp("full_sample", int'(sample), 4'b1101);
        en = 1'b0;
        run(6);

        // Sparse mask: only channels 1 and 3, two cycles each
        data = 4'b0010; chan_en = 4'b1010; dwell = 4'd1; en = 1'b1;
        tick();
        cmp("sparse_sel", int'(sel), 1);
        run(4);
        cmp("sparse_valid", int'(sample_valid), 1);
        cmp("sparse_sample", int'(sample), 4'b0010);
        en = 1'b0;
        run(6);

        // Single channel: pulse every four cycles
        data = 4'b0100; chan_en = 4'b0100; dwell = 4'd3; en = 1'b1;
        tick();
        run(4);
        cmp("single_valid", int'(sample_valid), 1);
        cmp("single_sample", int'(sample), 4'b0100);
        run(4);
        cmp("single_valid2", int'(sample_valid), 1);
        cmp("single_sel", int'(sel), 2);
        en = 1'b0;
        run(6);

        // en drops during the channel-2 dwell: one more pulse, then idle
        data = 4'b0101; chan_en = 4'b1111; dwell = 4'd1; en = 1'b1;
        run(5);
        cmp("endrop_sel", int'(sel), 2);
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sample_valid) pulses++;
        end
        cmp("endrop_pulses", pulses, 1);
        cmp("endrop_busy", int'(busy), 0);

        // Mask cleared mid-dwell: abort with the old snapshot kept
        data = 4'b1010; chan_en = 4'b1111; dwell = 4'd3; en = 1'b1;
        run(3);
        chan_en = 4'b0000;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sample_valid) pulses++;
        end
        cmp("abort_pulses", pulses, 0);
        cmp("abort_busy", int'(busy), 0);
        cmp("abort_sample", int'(sample), 4'b0101);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            data  = 4'($urandom);
            en    = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0)  chan_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) dwell   = 4'($urandom_range(0, 3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
Upstream sequencer for the 4:1 mux (mux4). Drives the mux select through the enabled channels in round-robin order and holds each channel for a programmable dwell time. It samples the mux output at the end of each dwell and, after each full sweep, publishes a 4-bit snapshot of all channels with a one-cycle valid strobe. Consumers read the snapshot instead of watching the mux output directly.

Parameters:
DWELL_W, 4, width of the dwell count input and the internal dwell counter
NCH, 4, channel count; fixed at 4 to match mux4; any other value is unsupported

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
en  input  1  scan enable; level-sensitive
chan_en  input  4  per-channel enable mask; bit i enables channel i
dwell  input  DWELL_W  channel hold time minus one, in cycles
mux_out  input  1  output of the downstream mux4, fed back for sampling
sel  output  2  select driven to mux4
sample  output  4  last completed sweep snapshot; bit i = channel i value
sample_valid  output  1  one-cycle pulse when sample updates
busy  output  1  high while a sweep is in progress

Behaviour:
- Reset is synchronous and active-high on clk, and overrides everything, including a sweep in progress. Reset values: sel=0, sample=0, sample_valid=0, busy=0, state=IDLE, counter=0, shadow=0.
- States are IDLE and DWELL. Encoding is 1 bit, defined in the package.
- IDLE:
  - busy=0 and sel holds its last value.
  - If en=1 and chan_en!=0: next cycle sel=lowest set bit of chan_en, counter=dwell, shadow=0, busy=1, state=DWELL.
  - If en=1 and chan_en=0: stay in IDLE.
- DWELL:
  - If counter!=0: counter decrements by 1 each cycle.
  - If counter==0 (end of dwell): shadow[sel] takes mux_out in the same cycle, and sel advances to the next set bit of chan_en strictly above sel, wrapping modulo 4.
  - chan_en is sampled only at the end of each dwell. Changes in mid-dwell have no effect until then.
- Sweep completion:
  - A sweep is complete when the advance wraps, i.e. next channel <= current sel, including the single-channel case.
  - On completion, the next cycle gives sample = shadow with the just-captured bit merged in, and sample_valid=1 for exactly one cycle.
  - Bits for channels not visited in the sweep read 0.
  - If en=1 and chan_en!=0 at completion: the next sweep starts immediately. Shadow is cleared, counter=dwell, and no IDLE cycle is inserted.
  - If en=0 at completion: state=IDLE and busy=0 in the same cycle that sample_valid rises.
- Early exit:
  - If en drops mid-sweep, the current sweep still finishes and publishes normally.
  - If chan_en==0 at an end of dwell, the sweep aborts to IDLE with no sample_valid and sample unchanged.
- Timing:
  - Each channel is held for dwell+1 cycles. dwell=0 means one cycle per channel.
  - Sweep period = (dwell+1) × number of enabled channels.
- mux_out is sampled combinationally against the current sel. The downstream mux4 is purely combinational, so no extra latency is modelled.
- Counter arithmetic is unsigned DWELL_W-bit. The counter never underflows, because it is reloaded at 0.

Decomposition:
- Shared package mux4_scan_pkg holds:
  - the state localparams S_IDLE=0 and S_DWELL=1;
  - NCH=4;
  - SEL_W=2.
- One sub-module: rr_next4, purely combinational.
  - Inputs: mask[3:0], cur[1:0].
  - Outputs: nxt[1:0], wrap, none.
  - Function: finds the next set bit above cur with wrap-around, or the lowest set bit when restarting.

Test Plan:
1. Reset mid-sweep: en=1, chan_en=4'b1111, dwell=2; assert reset at cycle 5 -> next cycle sel=0, busy=0, sample=0, sample_valid=0.
2. Full sweep, mux4 in loop with inputs a=1, b=0, c=1, d=1: chan_en=4'b1111, dwell=0 -> sel steps 0,1,2,3; sample=4'b1101 with sample_valid high one cycle, 4 cycles after busy rises.
3. Sparse mask: chan_en=4'b1010, dwell=1, b=1, d=0 -> sel visits only 1,3, each held 2 cycles; sample=4'b0010; period 4 cycles.
4. Single channel: chan_en=4'b0100, c=1, dwell=3 -> sel stays 2; sample=4'b0100 with sample_valid every 4 cycles.
5. en drop: deassert en during the channel-2 dwell of a 4'b1111 sweep -> sweep finishes, one sample_valid, then busy=0 and no further pulses.
6. Mask cleared mid-sweep: chan_en goes to 0 before the end of a dwell -> state returns to IDLE, no sample_valid, sample retains its previous value.
